// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART 8N1/8N2 transmitter that
// drains a first-word-fall-through FIFO.
module fifo_uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 1_000_000,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty,
  output logic       fifo_rget,
  input  logic       block,
  output logic       tx,
  output logic       busy
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CPB - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  if (CPB < 2) begin : g_bad_cpb
    $error("fifo_uart_tx: CLK_FREQ/BAUD must be >= 2");
  end

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic            stop_cnt;
  logic [CW-1:0]   clk_cnt;
  logic            armed;
  logic            bit_end;
  logic            last_stop;
  logic            launch;

  assign bit_end   = (clk_cnt == CLK_LAST);
  assign last_stop = (state == STOP) && bit_end
                   && (stop_cnt == STOP_LAST);

  // armed keeps pops off until one edge after reset release
  assign launch = armed && !fifo_empty && !block
                && ((state == IDLE) || last_stop);

  assign fifo_rget = launch;
  assign busy      = (state != IDLE);

  // one-cycle guard after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // frame sequencer; tx is loaded with the next slot's level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      clk_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (launch) begin
            state <= START;
            shreg <= fifo_dout;
            tx    <= 1'b0;
          end else begin
            tx <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            tx      <= shreg[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            shreg   <= {1'b0, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              state    <= STOP;
              stop_cnt <= 1'b0;
              tx       <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              if (launch) begin
                state <= START;
                shreg <= fifo_dout;
                tx    <= 1'b0;
              end else begin
                state <= IDLE;
                tx    <= 1'b1;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (!rst_n)
    fifo_rget |-> !fifo_empty
  );

  a_no_double_pop: assert property (
    @(posedge clk) disable iff (!rst_n)
    fifo_rget |=> !fifo_rget
  );
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: frame-level model plus
// directed scenarios for fifo_uart_tx.
module tb_fifo_uart_tx;

  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic blk;
  logic [7:0] dout0, dout1;
  logic empty0, empty1;
  logic hide0, hide1;
  logic rget0, rget1;
  logic tx0, tx1;
  logic busy0, busy1;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit up;
  bit act [2];
  int fstart [2];
  logic [7:0] fbyte [2];
  int busy_cnt [2];
  int rget_cnt [2];
  int low_cnt [2];
  int pc0 [$];
  int pc1 [$];
  logic txlog [2][16384];

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLK_FREQ(100), .BAUD(25), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .fifo_dout(dout0), .fifo_empty(empty0),
    .fifo_rget(rget0), .block(blk),
    .tx(tx0), .busy(busy0)
  );

  fifo_uart_tx #(
    .CLK_FREQ(100), .BAUD(25), .STOP_BITS(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .fifo_dout(dout1), .fifo_empty(empty1),
    .fifo_rget(rget1), .block(blk),
    .tx(tx1), .busy(busy1)
  );

  task automatic check(string nm, logic [31:0] a,
                       logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0h expected %0h cyc %0d",
                 nm, a, e, cyc);
    end
  endtask

  task automatic refresh();
    empty0 = (q0.size() == 0) || hide0;
    dout0  = (q0.size() != 0) ? q0[0] : 8'hEE;
    empty1 = (q1.size() == 0) || hide1;
    dout1  = (q1.size() != 0) ? q1[0] : 8'hEE;
  endtask

  task automatic push(int i, logic [7:0] b);
    if (i == 0) q0.push_back(b);
    else q1.push_back(b);
    refresh();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    busy_cnt = '{0, 0};
    rget_cnt = '{0, 0};
    low_cnt  = '{0, 0};
    pc0.delete();
    pc1.delete();
  endtask

  task automatic wait_pop(int i, int lim, output int p);
    int k = 0;
    int n;
    n = (i == 0) ? pc0.size() : pc1.size();
    while (k < lim && n == 0) begin
      step();
      k++;
      n = (i == 0) ? pc0.size() : pc1.size();
    end
    check("pop_seen", (n != 0), 1);
    p = (n == 0) ? 0 : ((i == 0) ? pc0[0] : pc1[0]);
  endtask

  task automatic check_slots(int i, int p, int n,
                             logic [10:0] pat, string nm);
    int idx;
    for (int s = 0; s < n; s++) begin
      idx = p + 1 + s * C + 2;
      if (idx >= 0 && idx < 16384)
        check($sformatf("%s_slot%0d", nm, s),
              txlog[i][idx], pat[s]);
      else
        check($sformatf("%s_range%0d", nm, s), idx, 0);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) up <= 1'b0;
    else up <= 1'b1;
  end

  // FIFO read side: pop on the edge that sees rget
  always @(posedge clk) begin
    bit p0, p1;
    p0 = rget0;
    p1 = rget1;
    #1;
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    refresh();
  end

  // frame-level model and per-cycle compare
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic t, b, r, e, etx, eb, er, inf;
      logic [7:0] d;
      int off, f, sl;
      t = (i == 0) ? tx0 : tx1;
      b = (i == 0) ? busy0 : busy1;
      r = (i == 0) ? rget0 : rget1;
      e = (i == 0) ? empty0 : empty1;
      d = (i == 0) ? dout0 : dout1;
      f = ((i == 0) ? 10 : 11) * C;
      if (!rst_n) begin
        act[i] = 1'b0;
        etx = 1'b1;
        eb  = 1'b0;
        er  = 1'b0;
      end else begin
        off = cyc - fstart[i];
        inf = act[i] && off < f;
        sl  = off / C;
        if (!inf) etx = 1'b1;
        else if (sl == 0) etx = 1'b0;
        else if (sl <= 8) etx = fbyte[i][sl-1];
        else etx = 1'b1;
        eb = inf;
        er = up && !e && !blk
           && (!inf || off == f - 1);
      end
      check($sformatf("tx%0d", i), t, etx);
      check($sformatf("busy%0d", i), b, eb);
      check($sformatf("rget%0d", i), r, er);
      check($sformatf("guard%0d", i), r && e, 0);
      if (rst_n && er) begin
        act[i]    = 1'b1;
        fstart[i] = cyc + 1;
        fbyte[i]  = d;
      end
      if (b) busy_cnt[i]++;
      if (r) rget_cnt[i]++;
      if (!t) low_cnt[i]++;
      if (r && i == 0) pc0.push_back(cyc);
      if (r && i == 1) pc1.push_back(cyc);
      if (cyc < 16384) txlog[i][cyc] = t;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, r, h;
    hide0 = 1'b0;
    hide1 = 1'b0;
    blk   = 1'b0;
    refresh();
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx0", tx0, 1);
    check("rst_busy0", busy0, 0);
    check("rst_rget0", rget0, 0);
    check("rst_tx1", tx1, 1);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // single byte
    clr();
    push(0, 8'hA5);
    wait_pop(0, 10, p);
    repeat (60) step();
    check("t1_pops", rget_cnt[0], 1);
    check("t1_busy", busy_cnt[0], 40);
    check_slots(0, p, 10, 11'b01101001010, "t1");
    check("t1_idle", tx0, 1);

    // back-to-back
    clr();
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h55);
    repeat (140) step();
    check("t2_pops", rget_cnt[0], 3);
    check("t2_busy", busy_cnt[0], 120);
    if (pc0.size() >= 3) begin
      check("t2_gap01", pc0[1] - pc0[0], 40);
      check("t2_gap12", pc0[2] - pc0[1], 40);
      check_slots(0, pc0[2], 10,
                  11'b01010101010, "t2");
    end
    check("t2_empty", q0.size(), 0);

    // block
    blk = 1'b1;
    clr();
    push(0, 8'h3E);
    push(0, 8'hC1);
    repeat (200) step();
    check("t3_held_pops", rget_cnt[0], 0);
    check("t3_held_low", low_cnt[0], 0);
    clr();
    r = cyc;
    blk = 1'b0;
    repeat (3) step();
    check("t3_pop_seen", pc0.size(), 1);
    check("t3_release_lat",
          (pc0.size() != 0) ? (pc0[0] - r <= 1) : 0, 1);
    p = (pc0.size() != 0) ? pc0[0] : 0;
    repeat (10) step();
    blk = 1'b1;
    repeat (60) step();
    check("t3_pops", rget_cnt[0], 1);
    check("t3_busy", busy_cnt[0], 40);
    check("t3_left", q0.size(), 1);
    check_slots(0, p, 10, 11'b01001111100, "t3");
    blk = 1'b0;
    repeat (60) step();
    check("t3_drain", q0.size(), 0);
    check("t3_idle", tx0, 1);

    // two stop bits
    clr();
    push(1, 8'h3C);
    push(1, 8'h81);
    repeat (110) step();
    check("t4_pops", rget_cnt[1], 2);
    check("t4_busy", busy_cnt[1], 88);
    if (pc1.size() >= 2) begin
      p = pc1[0];
      check("t4_gap", pc1[1] - pc1[0], 44);
      check_slots(1, p, 11, 11'b11001111000, "t4");
      h = 0;
      for (int k = p + 37; k < p + 45; k++)
        if (txlog[1][k] === 1'b1) h++;
      check("t4_stop_high", h, 8);
      check("t4_next_start", txlog[1][p + 45], 0);
    end

    // reset during data bit 3
    clr();
    push(0, 8'h11);
    push(0, 8'h22);
    wait_pop(0, 10, p);
    while (cyc < p + 18) step();
    #1 rst_n = 1'b0;
    #1;
    check("t5_tx", tx0, 1);
    check("t5_busy", busy0, 0);
    check("t5_rget", rget0, 0);
    repeat (3) step();
    clr();
    rst_n = 1'b1;
    repeat (60) step();
    check("t5_pops", rget_cnt[0], 1);
    check("t5_busy_cnt", busy_cnt[0], 40);
    check("t5_empty", q0.size(), 0);
    if (pc0.size() != 0)
      check_slots(0, pc0[0], 10,
                  11'b01001000100, "t5");

    // random empty/block toggling
    for (int n = 0; n < 10000; n++) begin
      step();
      hide0 = ($urandom_range(0, 3) == 0);
      hide1 = ($urandom_range(0, 3) == 0);
      blk   = ($urandom_range(0, 15) == 0);
      if (q0.size() < 3 && $urandom_range(0, 7) == 0)
        q0.push_back(8'($urandom));
      if (q1.size() < 3 && $urandom_range(0, 15) == 0)
        q1.push_back(8'($urandom));
      refresh();
    end
    hide0 = 1'b0;
    hide1 = 1'b0;
    blk   = 1'b0;
    refresh();
    begin
      int k = 0;
      while ((q0.size() != 0 || q1.size() != 0
              || busy0 || busy1) && k < 500) begin
        step();
        k++;
      end
    end
    check("t6_drain", q0.size() + q1.size(), 0);
    check("t6_idle", busy0 || busy1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

UART 8N1 transmitter that drains bytes from the read side of the `async_fifo` in its own clock domain. It is the consumer stage behind the FIFO: it pops one byte whenever it is ready and the FIFO is non-empty, then serialises the byte onto a single TX line. Consecutive frames go out back-to-back with no idle gap while data remains, and an external `block` input holds off new frames.

## Interface
- `CLK_FREQ`, default 100_000_000: `clk` frequency in Hz.
- `BAUD`, default 1_000_000: line rate in bits/s.
  - `CLKS_PER_BIT = CLK_FREQ / BAUD`, using integer division.
  - `CLKS_PER_BIT` must be ≥ 2; elaboration fails otherwise.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `clk`  in  1: single clock. This is the FIFO's `rclk` domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `fifo_dout`  in  8: FIFO head word. It is first-word-fall-through and valid whenever `fifo_empty` = 0.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rget`  out  1: pop strobe, one cycle. It is combinational from state, `fifo_empty` and `block`.
- `block`  in  1: while high, no new frame starts. A frame already in flight always completes.
- `tx`  out  1: serial line, registered, idle high.
- `busy`  out  1: high while a frame is on the line, meaning any state other than IDLE.

## Operation
- States: IDLE, START, DATA, STOP.
- Internal registers:
  - `shreg[7:0]`
  - `bit_cnt[2:0]`
  - `stop_cnt` (1 bit)
  - `clk_cnt`, width `$clog2(CLKS_PER_BIT)`, counting 0..CLKS_PER_BIT-1.
- `launch` = !`fifo_empty` && !`block` && (state==IDLE || last cycle of final stop bit).
- `fifo_rget` = `launch`. This is the only source of pops, so it never asserts while `fifo_empty` = 1.
- On `launch`:
  - `shreg` ← `fifo_dout`
  - `clk_cnt` ← 0
  - state ← START
- START:
  - `tx` = 0 for CLKS_PER_BIT cycles.
  - Then state → DATA and `bit_cnt` ← 0.
- DATA:
  - `tx` = `shreg[0]` for CLKS_PER_BIT cycles.
  - At each bit end, `shreg` shifts right and `bit_cnt` increments.
  - After bit 7, state → STOP and `stop_cnt` ← 0.
- STOP:
  - `tx` = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - On the last cycle: if `launch`, go to START (back-to-back frame); else go to IDLE.
- IDLE: `tx` = 1 and `clk_cnt` is held at 0.
- `block` is sampled only at launch points. Raising it mid-frame has no effect on that frame.
- `fifo_dout` is ignored except in the cycle `fifo_rget` = 1.
- Reset, whether asserted at power-up or mid-frame:
  - state = IDLE, `tx` = 1, `busy` = 0, `fifo_rget` = 0, all counters 0.
  - A partially sent byte is dropped; its FIFO entry was already popped.
  - Reset release is synchronous to `clk`, and the first launch happens no earlier than the first edge after release.

## Timing
- Pop to line:
  - `fifo_rget` is high in cycle N.
  - `tx` falls (start bit) on the edge ending cycle N, so the start bit is visible from cycle N+1.
- Frame length is (1 + 8 + STOP_BITS) × CLKS_PER_BIT cycles, measured exactly from the start-bit falling edge.
- Back-to-back:
  - The next start bit begins on the cycle immediately after the last stop-bit cycle.
  - There is no extra idle cycle.
  - The next pop occurs in that last stop-bit cycle.
- Bit order: LSB first.
- Bit k (0..7) occupies cycles [(1+k)×CLKS_PER_BIT, (2+k)×CLKS_PER_BIT) relative to the start-bit edge.
- `busy` timing:
  - Rises together with the start bit.
  - Falls on the cycle `tx` has completed the final stop bit, unless a back-to-back frame is launched, in which case it stays high.
- FIFO pop latency:
  - The FIFO presents the next head one cycle after `fifo_rget`.
  - The block never pops on consecutive cycles; the minimum spacing is one frame.

## Test plan
1. Single byte, with CLK_FREQ=100, BAUD=25 (4 clocks/bit), STOP_BITS=1. Push 0xA5 into an empty FIFO.
   - One `fifo_rget` pulse.
   - `tx` sequence per 4-cycle slot: 0,1,0,1,0,0,1,0,1,1.
   - `busy` high for exactly 40 cycles.
   - `tx` idles high afterwards.
2. Back-to-back: queue 0x00, 0xFF, 0x55.
   - Three frames with no idle cycles between them, 120 contiguous busy cycles.
   - `fifo_rget` pulses spaced exactly 40 cycles apart.
   - FIFO ends empty.
3. Block:
   - Hold `block` = 1 with 2 bytes queued: no `fifo_rget` and `tx` stays 1 for 200 cycles.
   - Release `block`: the first pop comes within 1 cycle.
   - Re-assert `block` mid-frame: the current frame completes and the second byte is held.
4. STOP_BITS=2: send 0x3C.
   - Frame is 44 cycles.
   - Stop period is 8 high cycles before the next start bit of a queued byte.
5. Reset mid-frame: assert `rst_n` = 0 during data bit 3.
   - `tx` = 1, `busy` = 0, `fifo_rget` = 0 immediately, with no clock needed.
   - After release, the next queued byte is sent cleanly.
   - The interrupted byte is not resent.
6. Empty guard: pulse `fifo_empty` 0→1 toggling around launch points.
   - `fifo_rget` is never high while `fifo_empty` = 1, checked by assertion over 10k random cycles.
